// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared width and result types for the registered ripple-carry adder
package rca_pkg;

  localparam int RCA_WIDTH = 4;

  typedef logic [RCA_WIDTH-1:0] rca_word_t;

  typedef struct {
    rca_word_t sum;
    logic      carry;
  } rca_result_t;

endpackage

// File: rtl/rca_full_adder.sv
// rtl/rca_full_adder.sv - single-bit combinational full-adder cell
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_4_bit.sv
// rtl/rca_4_bit.sv - 4-bit ripple-carry adder with registered {cout, out}
// Optional RCA_FLAGS_EN adds registered ovf and zero outputs.
module rca_4_bit
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
`ifdef RCA_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  rca_word_t   sum;
  logic        carry_out;
  rca_result_t res;

  // Each cell owns its carry so the chain is a set of distinct nets, cell to cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ci;
    logic co;
    logic s;

    if (i == 0) begin : g_c0
      assign ci = cin;
    end else begin : g_cn
      assign ci = g_cell[i-1].co;
    end

    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    assign sum[i] = s;
  end

  assign carry_out = g_cell[WIDTH-1].co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.sum   <= '0;
      res.carry <= 1'b0;
    end else begin
      res.sum   <= sum;
      res.carry <= carry_out;
    end
  end

  assign out  = res.sum;
  assign cout = res.carry;

`ifdef RCA_FLAGS_EN
  // ovf is the signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      ovf  <= carry_out ^ g_cell[WIDTH-1].ci;
      zero <= (sum == '0);
    end
  end
`endif

endmodule

// File: tb/tb_rca_4_bit.sv
// tb/tb_rca_4_bit.sv - randomized self-checking bench for rca_4_bit
// Flag checks are compiled in when RCA_FLAGS_EN is defined.
module tb_rca_4_bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] out;
  logic       cout;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
`ifdef RCA_FLAGS_EN
  logic       ovf;
  logic       zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rca_4_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out),
    .cout  (cout),
    .a     (a),
    .b     (b),
    .cin   (cin)
`ifdef RCA_FLAGS_EN
    ,
    .ovf   (ovf),
    .zero  (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result taken modulo 32.
  function automatic int model_sum(input int x, input int y, input int c);
    return (x + y + c) % 32;
  endfunction

  function automatic int model_ovf(input int x, input int y, input int c);
    int sx, sy, t;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    t  = sx + sy + c;
    return (t > 7 || t < -8) ? 1 : 0;
  endfunction

  task automatic check_result(input string tag, input int x, input int y, input int c);
    check(tag, int'({cout, out}), model_sum(x, y, c));
`ifdef RCA_FLAGS_EN
    check({tag, "_ovf"}, int'(ovf), model_ovf(x, y, c));
    check({tag, "_zero"}, int'(zero), ((model_sum(x, y, c) % 16) == 0) ? 1 : 0);
`endif
  endtask

  task automatic apply(input string tag, input int x, input int y, input int c);
    @(negedge clk);
    a   = 4'(x);
    b   = 4'(y);
    cin = 1'(c);
    @(posedge clk);
    #1;
    check_result(tag, x, y, c);
  endtask

  initial begin
    int rst_at;
    int x, y, c;

    rst_n = 1'b0;
    a     = 4'd15;
    b     = 4'd15;
    cin   = 1'b1;
    #1;
    check("reset_init", int'({cout, out}), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", int'({cout, out}), 0);
`ifdef RCA_FLAGS_EN
      check("reset_flags", int'({ovf, zero}), 0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_result("reset_release", 15, 15, 1);

    apply("dir_0_0_0", 0, 0, 0);
    apply("dir_9_6_0", 9, 6, 0);
    apply("dir_8_8_0", 8, 8, 0);
    apply("dir_7_8_1", 7, 8, 1);
`ifdef RCA_FLAGS_EN
    apply("flag_7_1_0", 7, 1, 0);
    apply("flag_3_2_0", 3, 2, 0);
`endif

    // Latency and hold: result only moves at the edge.
    apply("lat_pre", 0, 0, 0);
    @(negedge clk);
    a = 4'd3; b = 4'd4; cin = 1'b0;
    #1;
    check("lat_before_edge", int'({cout, out}), 0);
    @(posedge clk);
    #1;
    check("lat_first_edge", int'({cout, out}), 7);
    #2;
    a = 4'd10; b = 4'd5; cin = 1'b1;
    #1;
    check("lat_hold", int'({cout, out}), 7);
    @(posedge clk);
    #1;
    check("lat_second_edge", int'({cout, out}), 16);

    rst_at = int'($urandom_range(50, 450));
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      rst_n = 1'b1;
      x = v & 15;
      y = (v >> 4) & 15;
      c = (v >> 8) & 1;
      a = 4'(y);
      b = 4'(x);
      cin = 1'(c);
      @(posedge clk);
      #1;
      check_result("sweep", y, x, c);
      if (v == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", int'({cout, out}), 0);
        @(posedge clk);
        #1;
        check("midrst_hold", int'({cout, out}), 0);
      end
    end

    for (int k = 0; k < 200; k++) begin
      x = int'($urandom_range(0, 15));
      y = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 1));
      apply("random", x, y, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rca_4_bit.md
Name: rca_4_bit

Overview:
4-bit ripple-carry adder computing {cout, out} = a + b + cin, with the result captured in an output register.
- Serves as a small arithmetic leaf in datapaths that need a registered 5-bit sum.
- The carry ripples through a chain of full-adder cells.
- The registered stage gives one cycle of latency from operand sample to visible result.

Parameters:
- WIDTH, 4, operand/sum width in bits. Only 4 is supported; it exists so the chain is generated rather than hand-written.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- out  output  WIDTH  registered sum bits [3:0].
- cout  output  1  registered carry out of bit 3.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- Port order after clk, rst_n is out, cout, a, b, cin; positional instantiation relies on it.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Combinational core:
  - c[0] = cin.
  - For i in 0..3: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - Carry must ripple cell to cell. No lookahead, no behavioural "+" in the core.
- Register stage: on each rising clk with rst_n high, out <= s[3:0] and cout <= c[4].
- Latency: exactly 1 cycle. Operands sampled at edge N appear on out/cout after edge N and hold until edge N+1.
- Reset:
  - rst_n low clears out=0 and cout=0 immediately, independent of clk.
  - Registers hold 0 while rst_n is low.
  - The first edge after deassertion captures the current operands.
- Arithmetic is unsigned, modulo 32 on {cout, out}. Maximum 15+15+1=31 gives out=15, cout=1.
- No wrap or saturation logic: the carry is the only overflow indication in the base configuration.
- Reset mid-operation: any in-flight result is discarded. No stale value reappears after release.
- Inputs are assumed stable around the clk edge. There is no handshake; a new result is produced every cycle.
- No X propagation from reset: all outputs are defined from the first reset.

Optional Feature:
- Macro: RCA_FLAGS_EN.
- With the macro defined, two extra registered outputs follow cin:
  - ovf: 1-bit two's-complement overflow, c[4] ^ c[3].
  - zero: 1 when the registered out == 0, regardless of cout.
  - Both clear to 0 on reset and share the 1-cycle latency.
- Without the macro, these ports and their logic are absent, and the port list is exactly as above.

Decomposition:
- Package rca_pkg holds:
  - localparam RCA_WIDTH = 4.
  - typedef logic [RCA_WIDTH-1:0] rca_word_t.
  - typedef struct {rca_word_t sum; logic carry;} rca_result_t, used for the registered result.
- One sub-module, rca_full_adder (a, b, ci -> s, co), purely combinational.
  - Instantiated WIDTH times in a generate loop, chained ci/co.

Test Plan:
- Reset: hold rst_n=0 with a=15, b=15, cin=1 and toggle clk -> out=0, cout=0 throughout. Release; after the next edge -> out=15, cout=1.
- Directed sums, one cycle latency:
  - a=0, b=0, cin=0 -> out=0, cout=0.
  - a=9, b=6, cin=0 -> out=15, cout=0.
  - a=8, b=8, cin=0 -> out=0, cout=1.
  - a=7, b=8, cin=1 -> out=0, cout=1 (full ripple through all four cells).
- Exhaustive: drive {cin,a,b} = 0..511, one value per clock. Each result must equal (a+b+cin) one cycle later, with {cout,out} compared as a 5-bit value. 512/512 must match.
- Latency/hold: change operands every cycle from 3+4+0 to 10+5+1.
  - out=7 appears only after the first edge.
  - out=0 with cout=1 (sum 16) appears after the second edge.
  - Operands changed between edges do not alter outputs.
- Reset mid-stream: assert rst_n between edges during the exhaustive sweep -> outputs drop to 0 asynchronously. After release, the next captured result matches the current operands.
- RCA_FLAGS_EN build:
  - a=7, b=1, cin=0 -> ovf=1, zero=0.
  - a=8, b=8, cin=0 -> ovf=1, zero=1, cout=1.
  - a=3, b=2, cin=0 -> ovf=0, zero=0.
